// File: rtl/ahb_pkg.sv
// Shared AHB encodings and the subordinate's FSM state type.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01
    } hresp_t;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'b000,
        HSIZE_HALF = 3'b001,
        HSIZE_WORD = 3'b010
    } hsize_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } state_t;

endpackage

// File: rtl/ahb_byte_strobe.sv
// Little-endian byte lane enables for an AHB access of a given size and offset.
module ahb_byte_strobe
    import ahb_pkg::*;
(
    input  logic [1:0] addr,
    input  logic [2:0] size,
    output logic [3:0] strobe
);

    // Lane decode; illegal sizes enable no lanes.
    always_comb begin
        strobe = 4'b0000;
        case (size)
            HSIZE_BYTE: strobe = 4'b0001 << addr;
            HSIZE_HALF: strobe = addr[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: strobe = 4'b1111;
            default:    strobe = 4'b0000;
        endcase
    end

endmodule

// File: rtl/ahb_subordinate_mem.sv
// AHB subordinate fronting a word-organised memory, with configurable wait
// states and the two-cycle ERROR response for illegal accesses.
module ahb_subordinate_mem
    import ahb_pkg::*;
#(
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic        i_HCLK,
    input  logic        i_HRESETn,
    input  logic        i_HSEL,
    input  logic [31:0] i_HADDR,
    input  logic [1:0]  i_HTRANS,
    input  logic        i_HWRITE,
    input  logic [2:0]  i_HSIZE,
    input  logic [2:0]  i_HBURST,
    input  logic [31:0] i_HWDATA,
    input  logic        i_HREADY,
    output logic        o_HREADYOUT,
    output logic [1:0]  o_HRESP,
    output logic [31:0] o_HRDATA
);

    localparam int AW = $clog2(MEM_DEPTH);
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t          state;
    state_t          state_next;
    logic [3:0]      wait_cnt;
    logic            dp_active;
    logic            dp_write;
    logic [AW-1:0]   dp_addr;
    logic [3:0]      dp_strobe;
    logic [3:0]      addr_strobe;
    logic            accept;
    logic            illegal;
    logic            commit;
    logic [31:0]     mem [MEM_DEPTH];
    logic            unused_burst;

    // Burst type is irrelevant because every beat carries its own address.
    assign unused_burst = ^i_HBURST;

    ahb_byte_strobe u_strobe (
        .addr   (i_HADDR[1:0]),
        .size   (i_HSIZE),
        .strobe (addr_strobe)
    );

    // Acceptance is additionally gated by our own ready so a stalled data
    // phase can never be overrun by a stray address phase.
    assign accept  = i_HSEL && i_HREADY && o_HREADYOUT &&
                     (i_HTRANS == HTRANS_NONSEQ || i_HTRANS == HTRANS_SEQ);
    assign illegal = (i_HSIZE > HSIZE_WORD) ||
                     (i_HSIZE == HSIZE_HALF && i_HADDR[0]) ||
                     (i_HSIZE == HSIZE_WORD && i_HADDR[1:0] != 2'b00) ||
                     (|(i_HADDR >> (AW + 2)));

    // A legal data phase ends in IDLE, the only OKAY state with ready high.
    assign commit = dp_active && dp_write && (state == ST_IDLE);

    // State register.
    always_ff @(posedge i_HCLK or negedge i_HRESETn) begin
        if (!i_HRESETn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and response outputs.
    always_comb begin
        state_next  = state;
        o_HREADYOUT = 1'b1;
        o_HRESP     = HRESP_OKAY;
        case (state)
            ST_IDLE, ST_ERR2: begin
                o_HRESP = (state == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
                if (accept) begin
                    if (illegal) begin
                        state_next = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_next = ST_WAIT;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_WAIT: begin
                o_HREADYOUT = 1'b0;
                state_next  = (wait_cnt == 4'd0) ? ST_IDLE : ST_WAIT;
            end
            ST_ERR1: begin
                o_HREADYOUT = 1'b0;
                o_HRESP     = HRESP_ERROR;
                state_next  = ST_ERR2;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Wait-state counter and registered address-phase controls.
    always_ff @(posedge i_HCLK or negedge i_HRESETn) begin
        if (!i_HRESETn) begin
            wait_cnt  <= 4'd0;
            dp_active <= 1'b0;
            dp_write  <= 1'b0;
            dp_addr   <= '0;
            dp_strobe <= 4'b0000;
        end else begin
            if (accept) begin
                dp_active <= !illegal;
                dp_write  <= i_HWRITE;
                dp_addr   <= i_HADDR[AW+1:2];
                dp_strobe <= addr_strobe;
                if (!illegal) begin
                    wait_cnt <= WAIT_LOAD;
                end
            end else if (o_HREADYOUT) begin
                dp_active <= 1'b0;
            end
            if (state == ST_WAIT && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
        end
    end

    // Memory array, deliberately not reset; byte lanes commit independently.
    always_ff @(posedge i_HCLK) begin
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (dp_strobe[i]) begin
                    mem[dp_addr][8*i +: 8] <= i_HWDATA[8*i +: 8];
                end
            end
        end
    end

    assign o_HRDATA = (dp_active && !dp_write) ? mem[dp_addr] : 32'h0000_0000;

endmodule
